alu_serial_addsub: RTL and testbench

//   Multi-cycle digit-serial 64-bit add/subtract engine with Y86 condition codes (ZF/SF/OF).

---
 rtl/alu_serial_addsub_if.sv | 41 ++++
 rtl/alu_serial_addsub.sv | 160 ++++++++++++++++
 tb/tb_alu_serial_addsub.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_addsub_if
// Description : Handshake/operand bundle for the digit-serial add/subtract
//               engine.
//               master : drives start/op/a/b, observes busy/done/result/flags
//               slave  : the engine itself
//   start  request, sampled only while the engine is idle
//   op     0 = a+b, 1 = a-b
//   a, b   two's complement operands (WIDTH bits)
//   busy   engine is running or presenting a completion
//   done   one-cycle completion pulse
//   result sum/difference modulo 2^WIDTH
//   zf/sf/of  zero, sign and signed-overflow condition codes
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_addsub_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zf, sf, of
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zf, sf, of
  );
endinterface
`default_nettype wire

// File: rtl/alu_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_addsub
// Description : Multi-cycle digit-serial add/subtract engine producing
//               Y86 condition codes (ZF/SF/OF). Operands are captured on an
//               accepted start and consumed DIGIT bits per cycle, LSB first.
//               Result and flags update only when an operation completes.
// Ports       : clk  rising-edge clock
//               rst  asynchronous active-high reset
//               bus  alu_serial_addsub_if.slave (start/op/a/b in,
//                    busy/done/result/zf/sf/of out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_addsub #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  wire                   clk,
  input  wire                   rst,
  alu_serial_addsub_if.slave    bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;       // already complemented for subtraction
  logic             r_carry;
  logic             r_op;
  logic             r_sa;      // original operand signs, kept for OF
  logic             r_sb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shadow;  // partial sum, never visible on the outputs

  logic [WIDTH-1:0] r_result;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_done;

  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_shadow_next;
  logic             w_last;
  logic             w_sr;
  logic             w_of;

  // One digit of the ripple: low digit of each operand plus incoming carry.
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_carry};

  // New digit enters at the MSB end so after N shifts digit 0 sits at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign w_shadow_next = w_sum[DIGIT-1:0];
    end else begin : g_multi_digit
      assign w_shadow_next = {w_sum[DIGIT-1:0], r_shadow[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == C_LAST);
  assign w_sr   = w_shadow_next[WIDTH-1];
  // Subtraction overflows when the operand signs differ, addition when they
  // match; in both cases the result sign disagrees with operand A.
  assign w_of   = (r_op ? (r_sa != r_sb) : (r_sa == r_sb)) & (w_sr != r_sa);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, digit-serial add, completion write-back
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_op     <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // a - b is computed as a + ~b + 1: the +1 rides in as the carry.
            r_a     <= bus.a;
            r_b     <= bus.op ? ~bus.b : bus.b;
            r_carry <= bus.op;
            r_op    <= bus.op;
            r_sa    <= bus.a[WIDTH-1];
            r_sb    <= bus.b[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_carry  <= w_sum[DIGIT];
          r_shadow <= w_shadow_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_shadow_next;
            r_zf     <= (w_shadow_next == '0);
            r_sf     <= w_sr;
            r_of     <= w_of;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zf     = r_zf;
  assign bus.sf     = r_sf;
  assign bus.of     = r_of;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_addsub
// Description : Self-checking bench for alu_serial_addsub. Directed cases
//               plus randomized operands, compared against a signed
//               wide-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_addsub;

  localparam int WIDTH = 64;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  localparam logic signed [65:0] MAXV = 66'sd9223372036854775807;
  localparam logic signed [65:0] MINV = -MAXV - 66'sd1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] held_res;
  logic        held_zf, held_sf, held_of;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic two bits wider than the operands;
  // overflow means the true value does not fit in 64-bit two's complement.
  function automatic void model(input logic op_i, input logic [63:0] a_i,
                                input logic [63:0] b_i, output logic [63:0] r,
                                output logic z, output logic s, output logic o);
    logic signed [65:0] sa, sb, full;
    sa   = $signed({{2{a_i[63]}}, a_i});
    sb   = $signed({{2{b_i[63]}}, b_i});
    full = op_i ? (sa - sb) : (sa + sb);
    r    = full[63:0];
    z    = (r == 64'd0);
    s    = r[63];
    o    = (full > MAXV) || (full < MINV);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Issue one operation; optionally pulse a spurious start in RUN cycle
  // 'inject' (0 = none). Checks latency, result/flags, single done pulse.
  task automatic run_op(input string tag, input logic op_i, input logic [63:0] a_i,
                        input logic [63:0] b_i, input int inject);
    logic [63:0] er;
    logic        ez, es, eo;
    int          cyc;
    bit          seen;
    model(op_i, a_i, b_i, er, ez, es, eo);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    #1;
    // Operands only need to be valid at the capture edge.
    bus.start = 1'b0;
    bus.op    = ~op_i;
    bus.a     = rnd64();
    bus.b     = rnd64();
    chk_bit({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_hold"}, bus.result, held_res);

    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= N + 4 && !seen; i++) begin
      @(negedge clk);
      if (i == inject) begin
        bus.start = 1'b1;
        bus.op    = 1'($urandom_range(0, 1));
        bus.a     = rnd64();
        bus.b     = rnd64();
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(N));
    chk({tag, "_res"}, bus.result, er);
    chk_bit({tag, "_zf"}, bus.zf, ez);
    chk_bit({tag, "_sf"}, bus.sf, es);
    chk_bit({tag, "_of"}, bus.of, eo);
    chk_bit({tag, "_busy_done"}, bus.busy, 1'b1);

    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk_bit({tag, "_done_pulse"}, bus.done, 1'b0);
    chk_bit({tag, "_idle"}, bus.busy, 1'b0);
    chk({tag, "_stable"}, bus.result, er);
    held_res = er;
    held_zf  = ez;
    held_sf  = es;
    held_of  = eo;
  endtask

  task automatic check_zero(input string tag);
    chk_bit({tag, "_busy"}, bus.busy, 1'b0);
    chk_bit({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_res"}, bus.result, 64'd0);
    chk_bit({tag, "_zf"}, bus.zf, 1'b0);
    chk_bit({tag, "_sf"}, bus.sf, 1'b0);
    chk_bit({tag, "_of"}, bus.of, 1'b0);
  endtask

  initial begin
    logic        rop;
    logic [63:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    held_res  = '0;
    held_zf   = 1'b0;
    held_sf   = 1'b0;
    held_of   = 1'b0;
    rst       = 1'b1;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_op("sub_54_46",   1'b1, 64'd54, 64'd46, 0);
    run_op("sub_m1_10",   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0);
    run_op("sub_1000_m15", 1'b1, 64'd1000, -64'd15, 0);
    run_op("sub_m455_m45", 1'b1, -64'd455, -64'd45, 0);
    run_op("sub_ovf_pos", 1'b1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    run_op("sub_ovf_neg", 1'b1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 0);
    run_op("add_ovf",     1'b0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    run_op("add_zero",    1'b0, 64'd5, -64'd5, 0);
    run_op("sub_zero",    1'b1, 64'd5, 64'd5, 0);

    // Spurious start three cycles into RUN must be ignored
    run_op("ignore_start", 1'b0, 64'd123456789, 64'd987654321, 3);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 64'd77;
    bus.b     = 64'd88;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    @(negedge clk);
    rst      = 1'b0;
    held_res = '0;
    run_op("after_rst", 1'b1, 64'd300, 64'd1000, 0);

    // Randomized, back-to-back
    for (int i = 0; i < 16; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = rnd64();
      rb  = rnd64();
      if ($urandom_range(0, 3) == 0) ra = {ra[63], 63'h0} | (ra & 64'hFF);
      if ($urandom_range(0, 3) == 0) rb = {~ra[63], 63'h7FFF_FFFF_FFFF_FFFF};
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
